ps2_rx: RTL

PS/2 receive front end that sits directly upstream of the keyboard interface stage. It synchronises and deglitches the raw PS2C/PS2D lines and deserialises 11-bit device-to-host frames with odd-parity and stop-bit checking. It also folds the E0 (extended) and F0 (break) prefixes into a single key event, so the keyboard interface sees one make/break event per key. It runs on MCLK (25 MHz), not clk256, and never drives the PS/2 lines.

---
 rtl/ps2_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line sync/deglitch, 11-bit frame deserialiser,
// and E0/F0 prefix folding into single make/break key events.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic                  c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] flt;
    logic                  fclk;
    logic                  fall;
    logic                  timeout;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TO_W-1:0]       to_cnt;
    logic                  ext_pend, brk_pend;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
        end
    end

    // Clock deglitch: level only changes after FILTER_LEN agreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flt  <= '1;
            fclk <= 1'b1;
        end else begin
            flt <= {flt[FILTER_LEN-2:0], c_s2};
            if (flt == '0) begin
                fclk <= 1'b0;
            end else if (&flt) begin
                fclk <= 1'b1;
            end
        end
    end

    assign fall    = fclk && (flt == '0);
    assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Frame FSM, error/valid pulses and key assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        if (!d_s2) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {d_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par_bit <= d_s2;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!d_s2) begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end else if (!(^{shreg, par_bit})) begin
                            parity_err <= 1'b1;
                            ext_pend   <= 1'b0;
                            brk_pend   <= 1'b0;
                        end else begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else begin
                                key_code  <= shreg;
                                key_ext   <= ext_pend;
                                key_break <= brk_pend;
                                key_valid <= 1'b1;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Abandoned partial frame; never coincides with a fall
            if (timeout) begin
                state     <= IDLE;
                busy      <= 1'b0;
                shreg     <= '0;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end
        end
    end

endmodule
